mux_buf: RTL and testbench

MUX_BUF -- requirements
Module: mux_buf

---
 rtl/mux_buf_pkg.sv | 13 +
 rtl/mux_buf_fifo.sv | 42 ++++
 rtl/mux_buf.sv | 99 +++++++++
 tb/tb_mux_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_buf_pkg.sv
// Shared types and defaults for the channel-select output buffer.
package mux_buf_pkg;
  localparam int D_WIDTH_DEF    = 8;
  localparam int N_CH_DEF       = 3;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  // Select width for a channel count; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_buf_fifo.sv
// First-word-fall-through buffer; extra pointer bit separates full from empty.
module mux_buf_fifo #(
  parameter  int D_WIDTH = 8,
  parameter  int DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [D_WIDTH-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count
);
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]        wptr, rptr;
  logic               do_pop, do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop & ~empty;
  // A push into a full buffer only lands when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + {{AW{1'b0}}, do_push};
      rptr <= rptr + {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mux_buf.sv
// Routes one of N_CH channels into an output FIFO under an IDLE/STREAM/DRAIN FSM.
// Optional dropped-word counter enabled by defining MUX_BUF_OVF_CNT_EN.
module mux_buf
  import mux_buf_pkg::*;
#(
  parameter  int D_WIDTH    = D_WIDTH_DEF,
  parameter  int N_CH       = N_CH_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int SEL_W      = sel_w(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        select,
  input  logic [N_CH*D_WIDTH-1:0] data_i,
  input  logic [N_CH-1:0]         valid_i,
  input  logic                    ready_i,
  output logic [D_WIDTH-1:0]      data_o,
  output logic                    valid_o,
  output logic [SEL_W-1:0]        active_sel_o,
  output logic                    overflow_o,
  output logic [7:0]              ovf_cnt_o
);
  localparam int NSEL = 1 << SEL_W;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    active_sel, route_sel;
  logic [D_WIDTH-1:0]  ch_data [NSEL];
  logic [NSEL-1:0]     ch_vld;
  logic                push, pop, drop, full, empty, last_pop;
  logic [CW-1:0]       count;

  // Unused select codes map to a null channel that never strobes.
  for (genvar k = 0; k < NSEL; k++) begin : g_ch
    if (k < N_CH) begin : g_on
      assign ch_data[k] = data_i[k*D_WIDTH +: D_WIDTH];
      assign ch_vld[k]  = valid_i[k];
    end else begin : g_off
      assign ch_data[k] = '0;
      assign ch_vld[k]  = 1'b0;
    end
  end

  assign route_sel    = (state == IDLE) ? select : active_sel;
  assign push         = ch_vld[route_sel];
  assign valid_o      = ~empty;
  assign pop          = valid_o & ready_i;
  assign drop         = push & full & ~pop;
  assign last_pop     = pop && (count == CW'(1));
  assign active_sel_o = active_sel;

  mux_buf_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (ch_data[route_sel]),
    .rdata (data_o),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = STREAM;
      STREAM:  if (!push) state_nxt = (empty || last_pop) ? IDLE : DRAIN;
      DRAIN: begin
        if (push)                   state_nxt = STREAM;
        else if (empty || last_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      active_sel <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) active_sel <= select;
      if (drop) overflow_o <= 1'b1;
    end
  end

`ifdef MUX_BUF_OVF_CNT_EN
  logic [7:0] ovf_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end
  assign ovf_cnt_o = ovf_cnt;
`else
  assign ovf_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mux_buf.sv
// Self-checking bench for mux_buf: vector table, corner sequences, random vs queue model.
module tb_mux_buf;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  select;
  logic [23:0] data_i;
  logic [2:0]  valid_i;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic [1:0]  active_sel_o;
  logic        overflow_o;
  logic [7:0]  ovf_cnt_o;

  int tests = 0;
  int fails = 0;

  mux_buf dut (
    .clk(clk), .rst_n(rst_n), .select(select), .data_i(data_i), .valid_i(valid_i),
    .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o), .active_sel_o(active_sel_o),
    .overflow_o(overflow_o), .ovf_cnt_o(ovf_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: a word queue plus the mode rules, evaluated once per edge.
  int q[$];
  int m_mode;   // 0 idle, 1 streaming, 2 draining
  int m_asel;
  bit m_ovf;
  int m_cnt;

  function automatic int exp_cnt(input int c);
`ifdef MUX_BUF_OVF_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic m_reset();
    q.delete();
    m_mode = 0; m_asel = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int route;
    bit v, p;
    route = (m_mode == 0) ? int'(select) : m_asel;
    v = 0;
    if (route < 3) v = valid_i[route];
    p = (q.size() > 0) && ready_i;
    if (p) void'(q.pop_front());
    if (v) begin
      if (q.size() < 4) q.push_back(int'(data_i[route*8 +: 8]));
      else begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (m_mode == 0) m_asel = int'(select);
    case (m_mode)
      0: if (v) m_mode = 1;
      1: if (!v) m_mode = (q.size() == 0) ? 0 : 2;
      default: if (v) m_mode = 1; else if (q.size() == 0) m_mode = 0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; select = '0; valid_i = '0; data_i = '0; ready_i = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  v;
    logic [23:0] d;
    logic        rdy;
    logic        evo;
    logic [7:0]  edo;
    logic        eovf;
    int          ecnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit seen;
    // Basic routing, then ch0 backpressure with one drop and in-order drain.
    tbl[0]  = '{2'd1, 3'b010, 24'h004100, 1'b1, 1'b1, 8'h41, 1'b0, 0};
    tbl[1]  = '{2'd1, 3'b000, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    tbl[2]  = '{2'd0, 3'b000, 24'h000000, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    tbl[3]  = '{2'd0, 3'b001, 24'h000010, 1'b0, 1'b1, 8'h10, 1'b0, 0};
    tbl[4]  = '{2'd0, 3'b001, 24'h000011, 1'b0, 1'b1, 8'h10, 1'b0, 0};
    tbl[5]  = '{2'd0, 3'b001, 24'h000012, 1'b0, 1'b1, 8'h10, 1'b0, 0};
    tbl[6]  = '{2'd0, 3'b001, 24'h000013, 1'b0, 1'b1, 8'h10, 1'b0, 0};
    tbl[7]  = '{2'd0, 3'b001, 24'h000014, 1'b0, 1'b1, 8'h10, 1'b1, 1};
    tbl[8]  = '{2'd0, 3'b000, 24'h000000, 1'b1, 1'b1, 8'h11, 1'b1, 1};
    tbl[9]  = '{2'd0, 3'b000, 24'h000000, 1'b1, 1'b1, 8'h12, 1'b1, 1};
    tbl[10] = '{2'd0, 3'b000, 24'h000000, 1'b1, 1'b1, 8'h13, 1'b1, 1};
    tbl[11] = '{2'd0, 3'b000, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b1, 1};
    tbl[12] = '{2'd0, 3'b000, 24'h000000, 1'b0, 1'b0, 8'h00, 1'b1, 1};

    rst_n = 1'b0; select = '0; valid_i = '0; data_i = '0; ready_i = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_cnt", ovf_cnt_o, 0);
    chk("rst_asel", active_sel_o, 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      select = tbl[i].sel; valid_i = tbl[i].v; data_i = tbl[i].d; ready_i = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].evo);
      chk($sformatf("tbl%0d_data", i), data_o, tbl[i].edo);
      chk($sformatf("tbl%0d_ovf", i), overflow_o, tbl[i].eovf);
      chk($sformatf("tbl%0d_cnt", i), ovf_cnt_o, exp_cnt(tbl[i].ecnt));
    end

    // Deferred select: ch2 request while ch0 words are still buffered.
    do_reset();
    select = 2'd0; valid_i = 3'b001; data_i = 24'h000030; step();
    data_i = 24'h000031; step();
    select = 2'd2; valid_i = 3'b100; data_i = 24'hAA0000;
    repeat (3) step();
    chk("defer_asel_hold", active_sel_o, 0);
    chk("defer_head", data_o, 8'h30);
    valid_i = 3'b000; ready_i = 1'b1; step();
    chk("defer_drain1", data_o, 8'h31);
    chk("defer_asel_drain", active_sel_o, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (active_sel_o == 2'd2) seen = 1;
    end
    chk("defer_asel_switch", seen, 1);
    chk("defer_empty", valid_o, 0);
    valid_i = 3'b100; data_i = 24'hC20000; ready_i = 1'b0; step();
    chk("defer_ch2_valid", valid_o, 1);
    chk("defer_ch2_data", data_o, 8'hC2);

    // Full buffer with simultaneous push and pop.
    do_reset();
    select = 2'd0; valid_i = 3'b001;
    for (int i = 0; i < 4; i++) begin
      data_i = 24'h000050 + 24'(i); step();
    end
    data_i = 24'h000055; ready_i = 1'b1; step();
    chk("fullpp_ovf", overflow_o, 0);
    chk("fullpp_head", data_o, 8'h51);
    valid_i = 3'b000;
    step(); chk("fullpp_w2", data_o, 8'h52);
    step(); chk("fullpp_w3", data_o, 8'h53);
    step(); chk("fullpp_w4", data_o, 8'h55);
    step(); chk("fullpp_empty", valid_o, 0);

    // Null route: out-of-range select keeps the block idle.
    do_reset();
    select = 2'd3; valid_i = 3'b111; data_i = 24'hFFFFFF; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk($sformatf("null_valid%0d", i), valid_o, 0);
    end
    chk("null_asel", active_sel_o, 3);
    select = 2'd1; valid_i = 3'b000; step();
    chk("null_still_idle", active_sel_o, 1);

    // Asynchronous reset between edges with two words buffered.
    do_reset();
    select = 2'd0; valid_i = 3'b001; data_i = 24'h000060; step();
    data_i = 24'h000061; step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("areset_valid", valid_o, 0);
    chk("areset_data", data_o, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; valid_i = 3'b001; data_i = 24'h000077; ready_i = 1'b0;
    step();
    chk("areset_first_valid", valid_o, 1);
    chk("areset_first_data", data_o, 8'h77);
    valid_i = 3'b000; ready_i = 1'b1; step();
    chk("areset_drained", valid_o, 0);

    // Random traffic against the queue model; heavy backpressure first.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      select  = 2'($urandom_range(0, 3));
      valid_i = 3'($urandom);
      data_i  = 24'($urandom);
      ready_i = ($urandom_range(0, 99) < ((i < 1500) ? 10 : 60));
      step();
      chk("rnd_valid", valid_o, (q.size() > 0));
      chk("rnd_data", data_o, (q.size() > 0) ? q[0] : 0);
      chk("rnd_ovf", overflow_o, m_ovf);
      chk("rnd_asel", active_sel_o, m_asel);
      chk("rnd_cnt", ovf_cnt_o, exp_cnt(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
